// File: rtl/counter_pkg.sv
// Shared sizing constants for the sample counter and the datapath
// registers that are compared against it.
package counter_pkg;

   localparam int unsigned COUNTER_DEFAULT_WIDTH = 32;
   localparam int unsigned COUNTER_DEFAULT_RESET = 0;

endpackage

// File: rtl/counter.sv
// Sample counter with two synchronous clears and a count enable.
// Define COUNTER_SATURATE_EN to hold at all ones instead of wrapping.
module counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = COUNTER_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(COUNTER_DEFAULT_RESET)
) (
   input  logic             clk,
   input  logic             en,
   input  logic             rst,
   input  logic             reset,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] countQ;
   logic [WIDTH-1:0] countNext;

`ifdef COUNTER_SATURATE_EN
   logic atMax;

   assign atMax = &countQ;

   always_comb begin
      countNext = countQ;
      if (en && !atMax) begin
         countNext = countQ + 1'b1;
      end
   end
`else
   always_comb begin
      countNext = countQ;
      if (en) begin
         countNext = countQ + 1'b1;
      end
   end
`endif

   // Either clear beats the enable; the cleared value is not bumped.
   always_ff @(posedge clk) begin
      if (rst || reset) begin
         countQ <= RESET_VALUE;
      end else begin
         countQ <= countNext;
      end
   end

   assign count = countQ;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: a default 32-bit instance and a
// 4-bit instance share stimulus so wrap/saturation is exercised.
module tb_counter;

   logic       clk;
   logic       en;
   logic       rst;
   logic       reset;
   logic [31:0] countWide;
   logic [3:0]  countNarrow;

   int checks;
   int errors;

   logic [31:0] modelWide;
   logic [3:0]  modelNarrow;
   logic [31:0] expWideQ[$];
   logic [3:0]  expNarrowQ[$];

   counter dutWide (
      .clk   (clk),
      .en    (en),
      .rst   (rst),
      .reset (reset),
      .count (countWide)
   );

   counter #(.WIDTH(4)) dutNarrow (
      .clk   (clk),
      .en    (en),
      .rst   (rst),
      .reset (reset),
      .count (countNarrow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag,
                           input logic [63:0] got,
                           input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle, push the model's prediction, then pop and compare.
   task automatic step(input string tag, input logic e,
                       input logic r, input logic lr);
      logic [31:0] w;
      logic [3:0]  n;
      @(negedge clk);
      en = e;
      rst = r;
      reset = lr;
      if (r || lr) begin
         modelWide = '0;
         modelNarrow = '0;
      end else if (e) begin
         modelWide = modelWide + 32'd1;
`ifdef COUNTER_SATURATE_EN
         if (modelNarrow != 4'hF) modelNarrow = modelNarrow + 4'd1;
`else
         modelNarrow = modelNarrow + 4'd1;
`endif
      end
      expWideQ.push_back(modelWide);
      expNarrowQ.push_back(modelNarrow);
      @(posedge clk);
      #1;
      if (expWideQ.size() == 0 || expNarrowQ.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard empty", tag);
      end else begin
         w = expWideQ.pop_front();
         n = expNarrowQ.pop_front();
         checkVal({tag, "_w32"}, 64'(countWide), 64'(w));
         checkVal({tag, "_w4"}, 64'(countNarrow), 64'(n));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      en = 1'b0;
      rst = 1'b0;
      reset = 1'b0;
      modelWide = '0;
      modelNarrow = '0;

      for (int i = 0; i < 2; i++) step("rst", 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("count", 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) step("hold", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) step("to7", 1'b1, 1'b0, 1'b0);
      step("lclr", 1'b1, 1'b0, 1'b1);
      step("resume", 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("prioRst", 1'b1, 1'b1, 1'b0);
      step("bump", 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("prioClr", 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 18; i++) step("wrapSat", 1'b1, 1'b0, 1'b0);
      step("satClr", 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 60; i++) begin
         step("rand", 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 19) == 0),
              1'($urandom_range(0, 19) == 0));
      end

      checkVal("sbDrain", 64'(expWideQ.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule
